sram_burst_bridge: RTL and testbench

- Parametrised successor to the AVR↔SRAM bus FSM and address shift register.
- Combines serial address loading, an address counter with auto-increment and wrap, and a read/write sequencer with programmable SRAM wait states.
- Sits between the AVR control pins and the SRAM pins. All buses are split in/out/oe, and the system top builds the tristates.
- Lets the AVR stream consecutive bytes without reloading the address.

---
 rtl/sram_burst_bridge_if.sv | 57 +++++
 rtl/sram_burst_bridge.sv | 184 ++++++++++++++++++
 tb/tb_sram_burst_bridge.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_bridge_if.sv
// ---------------------------------------------------------------------------
// sram_burst_bridge_if
// Bundles the AVR-side control/data pins and the SRAM-side pins handled by
// sram_burst_bridge. All buses are split into in/out/oe; the system top
// builds the actual tristate pads.
//
// Signals:
//   avr_si, avr_sreg_en        serial address bit (MSB first) and shift enable
//   avr_oe, avr_we             active-low read / write requests
//   avr_counter                active-low address increment request
//   avr_data_in / avr_data_out write data from AVR / read data back to AVR
//   avr_data_oe                drive avr_data_out onto the AVR bus
//   avr_ready, avr_busy        access-complete pulse, sequencer-active flag
//   sram_addr                  SRAM address
//   sram_data_in/out, _oe      SRAM read data, write data, write-data enable
//   sram_ce_n/oe_n/we_n        SRAM strobes, active-low
//
// Modports: slave = the bridge itself, master = the AVR/SRAM environment.
// ---------------------------------------------------------------------------
interface sram_burst_bridge_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 8
);
    logic                  avr_si;
    logic                  avr_sreg_en;
    logic                  avr_oe;
    logic                  avr_we;
    logic                  avr_counter;
    logic [DATA_WIDTH-1:0] avr_data_in;
    logic [DATA_WIDTH-1:0] avr_data_out;
    logic                  avr_data_oe;
    logic                  avr_ready;
    logic                  avr_busy;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_data_in;
    logic [DATA_WIDTH-1:0] sram_data_out;
    logic                  sram_data_oe;
    logic                  sram_ce_n;
    logic                  sram_oe_n;
    logic                  sram_we_n;

    modport slave (
        input  avr_si, avr_sreg_en, avr_oe, avr_we, avr_counter, avr_data_in,
        input  sram_data_in,
        output avr_data_out, avr_data_oe, avr_ready, avr_busy,
        output sram_addr, sram_data_out, sram_data_oe,
        output sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output avr_si, avr_sreg_en, avr_oe, avr_we, avr_counter, avr_data_in,
        output sram_data_in,
        input  avr_data_out, avr_data_oe, avr_ready, avr_busy,
        input  sram_addr, sram_data_out, sram_data_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_burst_bridge.sv
// ---------------------------------------------------------------------------
// sram_burst_bridge
// Bridge between AVR control pins and an asynchronous SRAM. Combines a serial
// address shift register, an address counter (auto-increment with wrap) and
// a read/write sequencer with programmable SRAM wait states, so the AVR can
// stream consecutive bytes without reloading the address.
//
// Ports:
//   avr_clk    system clock, everything on the rising edge
//   avr_reset  synchronous reset, active-high
//   bus        sram_burst_bridge_if.slave (AVR and SRAM pins)
//
// Parameters:
//   ADDR_WIDTH   SRAM address / shift register width
//   DATA_WIDTH   data bus width
//   WAIT_CYCLES  extra cycles the SRAM strobes stay asserted (0..15)
//   AUTO_INC     1 = address advances by one after every completed access
// ---------------------------------------------------------------------------
module sram_burst_bridge #(
    parameter int ADDR_WIDTH  = 21,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int AUTO_INC    = 1
) (
    input logic                 avr_clk,
    input logic                 avr_reset,
    sram_burst_bridge_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACT,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] done_inc;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] wr_buf;
    logic [3:0]            wait_cnt;
    logic                  oe_q, we_q, cnt_q;
    logic                  armed;
    logic                  oe_fall, we_fall, cnt_fall;
    logic                  rd_req, wr_req, cnt_req;
    logic                  pending_inc;
    logic                  ready_q, busy_q, data_oe_q;
    logic                  ce_n_q, oe_n_q, we_n_q;

    // Falling-edge detectors. 'armed' stays low for the first cycle after
    // reset so a request line already held low at release is not mistaken
    // for a fresh falling edge.
    assign oe_fall  = armed & oe_q  & ~bus.avr_oe;
    assign we_fall  = armed & we_q  & ~bus.avr_we;
    assign cnt_fall = armed & cnt_q & ~bus.avr_counter;

    // Completion step: auto-increment plus any counter request collected
    // while busy, including one that lands on the completion cycle itself.
    assign done_inc = ADDR_WIDTH'(AUTO_INC) + ADDR_WIDTH'(pending_inc | cnt_req);

    // Sequencer, address register and all registered outputs. Requests are
    // first latched into rd_req/wr_req/cnt_req; the FSM acts on them one
    // cycle later. Requests arriving while not IDLE are dropped, except the
    // counter request, which is held one-deep in pending_inc.
    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            state       <= IDLE;
            addr        <= '0;
            rd_data     <= '0;
            wr_buf      <= '0;
            wait_cnt    <= '0;
            oe_q        <= 1'b1;
            we_q        <= 1'b1;
            cnt_q       <= 1'b1;
            armed       <= 1'b0;
            rd_req      <= 1'b0;
            wr_req      <= 1'b0;
            cnt_req     <= 1'b0;
            pending_inc <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            data_oe_q   <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            oe_q    <= bus.avr_oe;
            we_q    <= bus.avr_we;
            cnt_q   <= bus.avr_counter;
            armed   <= 1'b1;
            rd_req  <= (state == IDLE) && oe_fall && bus.avr_we;
            wr_req  <= (state == IDLE) && we_fall && bus.avr_oe;
            cnt_req <= cnt_fall;
            ready_q <= 1'b0;

            if ((state == IDLE) && we_fall && bus.avr_oe) begin
                wr_buf <= bus.avr_data_in;
            end

            if (cnt_req && (state != IDLE)) begin
                pending_inc <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.avr_sreg_en) begin
                        addr <= {addr[ADDR_WIDTH-2:0], bus.avr_si};
                    end else if (cnt_req) begin
                        if (rd_req || wr_req) begin
                            pending_inc <= 1'b1;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                    if (rd_req) begin
                        state    <= RD_ACT;
                        busy_q   <= 1'b1;
                        ce_n_q   <= 1'b0;
                        oe_n_q   <= 1'b0;
                        wait_cnt <= '0;
                    end else if (wr_req) begin
                        state     <= WR_SETUP;
                        busy_q    <= 1'b1;
                        ce_n_q    <= 1'b0;
                        data_oe_q <= 1'b1;
                    end
                end
                RD_ACT: begin
                    if (wait_cnt == 4'(WAIT_CYCLES)) begin
                        state   <= RD_DONE;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        ready_q <= 1'b1;
                        rd_data <= bus.sram_data_in;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WR_SETUP: begin
                    state    <= WR_PULSE;
                    we_n_q   <= 1'b0;
                    wait_cnt <= '0;
                end
                WR_PULSE: begin
                    if (wait_cnt == 4'(WAIT_CYCLES)) begin
                        state   <= WR_HOLD;
                        we_n_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RD_DONE, WR_HOLD: begin
                    state       <= IDLE;
                    busy_q      <= 1'b0;
                    ce_n_q      <= 1'b1;
                    oe_n_q      <= 1'b1;
                    we_n_q      <= 1'b1;
                    data_oe_q   <= 1'b0;
                    addr        <= addr + done_inc;
                    pending_inc <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.avr_data_out  = rd_data;
    assign bus.avr_data_oe   = ~bus.avr_oe & bus.avr_we;
    assign bus.avr_ready     = ready_q;
    assign bus.avr_busy      = busy_q;
    assign bus.sram_addr     = addr;
    assign bus.sram_data_out = wr_buf;
    assign bus.sram_data_oe  = data_oe_q;
    assign bus.sram_ce_n     = ce_n_q;
    assign bus.sram_oe_n     = oe_n_q;
    assign bus.sram_we_n     = we_n_q;

endmodule

// File: tb/tb_sram_burst_bridge.sv
// ---------------------------------------------------------------------------
// tb_sram_burst_bridge
// Directed bench for sram_burst_bridge (ADDR_WIDTH=21, DATA_WIDTH=8,
// WAIT_CYCLES=1, AUTO_INC=1). A table of read/write transactions with
// hand-computed results, followed by hand-written sequences for counter,
// wrap, dropped-request and reset corner cases.
// ---------------------------------------------------------------------------
module tb_sram_burst_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sram_burst_bridge_if #(.ADDR_WIDTH(21), .DATA_WIDTH(8)) bus ();

    sram_burst_bridge #(
        .ADDR_WIDTH (21),
        .DATA_WIDTH (8),
        .WAIT_CYCLES(1),
        .AUTO_INC   (1)
    ) dut (
        .avr_clk  (clk),
        .avr_reset(rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_wr;
        int          shift_bits;
        logic [20:0] shift_val;
        logic [20:0] pre_addr;
        logic [7:0]  data;
        int          exp_lat;
        int          exp_ce;
        int          exp_strobe;
        int          exp_doe;
        logic [20:0] post_addr;
    } vec_t;

    vec_t vecs[5];

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Shift the low 'nbits' of 'val' into the address register, MSB first.
    task automatic applyStimulus(input logic [20:0] val, input int nbits);
        logic [20:0] v;
        v = val;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.avr_si      = v[i];
            bus.avr_sreg_en = 1'b1;
            tick();
        end
        bus.avr_sreg_en = 1'b0;
        bus.avr_si      = 1'b0;
        tick();
    endtask

    // Run one read or write and record strobe activity per cycle. Cycle k=1
    // is the edge that first sees the request line low.
    task automatic runAccess(input logic is_wr, input logic [7:0] d,
                             output int rdy, output int lat, output int ce,
                             output int oe, output int we, output int doe,
                             output int ce_first, output int we_first);
        rdy = 0; lat = -1; ce = 0; oe = 0; we = 0; doe = 0;
        ce_first = -1; we_first = -1;
        if (is_wr) begin
            bus.avr_data_in = d;
            bus.avr_we      = 1'b0;
        end else begin
            bus.sram_data_in = d;
            bus.avr_oe       = 1'b0;
        end
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) begin
                bus.avr_data_in  = ~d;
            end
            if (bus.avr_ready) begin
                rdy++;
                if (lat < 0) lat = k;
            end
            if (!bus.sram_ce_n) begin
                ce++;
                if (ce_first < 0) ce_first = k;
            end
            if (!bus.sram_oe_n) oe++;
            if (!bus.sram_we_n) begin
                we++;
                if (we_first < 0) we_first = k;
            end
            if (bus.sram_data_oe) doe++;
        end
        bus.avr_we       = 1'b1;
        bus.avr_oe       = 1'b1;
        bus.sram_data_in = ~d;
        tick();
    endtask

    initial begin
        int rdy, lat, ce, oe, we, doe, ce_first, we_first;
        int busy_cnt;

        vecs[0] = '{1'b0, 16, 21'h0999F,  21'h0999F,  8'hAA, 4, 2, 2, 0, 21'h099A0};
        vecs[1] = '{1'b1,  0, 21'h00000,  21'h099A0,  8'hEE, 5, 4, 2, 4, 21'h099A1};
        vecs[2] = '{1'b0, 21, 21'h1FFFFF, 21'h1FFFFF, 8'h5C, 4, 2, 2, 0, 21'h00000};
        vecs[3] = '{1'b1, 21, 21'h0FFFF,  21'h0FFFF,  8'h3C, 5, 4, 2, 4, 21'h10000};
        vecs[4] = '{1'b0,  0, 21'h00000,  21'h10000,  8'hC3, 4, 2, 2, 0, 21'h10001};

        bus.avr_si       = 1'b0;
        bus.avr_sreg_en  = 1'b0;
        bus.avr_oe       = 1'b1;
        bus.avr_we       = 1'b1;
        bus.avr_counter  = 1'b1;
        bus.avr_data_in  = 8'h00;
        bus.sram_data_in = 8'h00;

        rst = 1'b1;
        tick(); tick(); tick();
        checkOutput("reset addr", 32'(bus.sram_addr), 32'h0);
        checkOutput("reset strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 32'h7);
        checkOutput("reset busy/ready/oe", {bus.avr_busy, bus.avr_ready, bus.sram_data_oe}, 32'h0);
        checkOutput("reset data regs", {bus.avr_data_out, bus.sram_data_out}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].shift_bits > 0) begin
                applyStimulus(vecs[i].shift_val, vecs[i].shift_bits);
            end
            checkOutput($sformatf("v%0d pre addr", i), 32'(bus.sram_addr), 32'(vecs[i].pre_addr));
            checkOutput($sformatf("v%0d idle strobes", i),
                        {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 32'h7);
            runAccess(vecs[i].is_wr, vecs[i].data, rdy, lat, ce, oe, we, doe, ce_first, we_first);
            checkOutput($sformatf("v%0d ready pulses", i), 32'(rdy), 32'd1);
            checkOutput($sformatf("v%0d ready latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d ce_n low cycles", i), 32'(ce), 32'(vecs[i].exp_ce));
            checkOutput($sformatf("v%0d data_oe cycles", i), 32'(doe), 32'(vecs[i].exp_doe));
            if (vecs[i].is_wr) begin
                checkOutput($sformatf("v%0d we_n low cycles", i), 32'(we), 32'(vecs[i].exp_strobe));
                checkOutput($sformatf("v%0d oe_n during write", i), 32'(oe), 32'd0);
                checkOutput($sformatf("v%0d write setup", i), 32'(we_first - ce_first), 32'd1);
                checkOutput($sformatf("v%0d write data", i), 32'(bus.sram_data_out), 32'(vecs[i].data));
            end else begin
                checkOutput($sformatf("v%0d oe_n low cycles", i), 32'(oe), 32'(vecs[i].exp_strobe));
                checkOutput($sformatf("v%0d we_n during read", i), 32'(we), 32'd0);
                checkOutput($sformatf("v%0d read data", i), 32'(bus.avr_data_out), 32'(vecs[i].data));
            end
            checkOutput($sformatf("v%0d post addr", i), 32'(bus.sram_addr), 32'(vecs[i].post_addr));
        end

        // Counter pulse while idle: 0x10001 -> 0x10002.
        bus.avr_counter = 1'b0;
        tick();
        bus.avr_counter = 1'b1;
        tick(); tick(); tick();
        checkOutput("idle counter", 32'(bus.sram_addr), 32'h10002);

        // Counter pulse during a read at the top address: wraps to 1.
        applyStimulus(21'h1FFFFF, 21);
        checkOutput("wrap pre addr", 32'(bus.sram_addr), 32'h1FFFFF);
        bus.sram_data_in = 8'h42;
        bus.avr_oe       = 1'b0;
        tick();
        bus.avr_counter = 1'b0;
        tick();
        bus.avr_counter = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        bus.avr_oe = 1'b1;
        tick();
        checkOutput("wrap with pending inc", 32'(bus.sram_addr), 32'h000001);
        checkOutput("wrap read data", 32'(bus.avr_data_out), 32'h42);

        // oe and we falling together: no access at all.
        busy_cnt = 0; ce = 0;
        bus.avr_oe = 1'b0;
        bus.avr_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.avr_busy) busy_cnt++;
            if (!bus.sram_ce_n) ce++;
        end
        bus.avr_oe = 1'b1;
        bus.avr_we = 1'b1;
        tick();
        checkOutput("simultaneous busy", 32'(busy_cnt), 32'd0);
        checkOutput("simultaneous ce_n", 32'(ce), 32'd0);
        checkOutput("simultaneous addr", 32'(bus.sram_addr), 32'h000001);

        // oe edge arriving during a write is dropped.
        rdy = 0; oe = 0;
        bus.avr_data_in = 8'h77;
        bus.avr_we      = 1'b0;
        tick();
        bus.avr_we = 1'b1;
        tick();
        bus.avr_oe = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.avr_ready) rdy++;
            if (!bus.sram_oe_n) oe++;
        end
        bus.avr_oe = 1'b1;
        tick();
        checkOutput("dropped oe ready pulses", 32'(rdy), 32'd1);
        checkOutput("dropped oe oe_n", 32'(oe), 32'd0);
        checkOutput("dropped oe write data", 32'(bus.sram_data_out), 32'h77);
        checkOutput("dropped oe addr", 32'(bus.sram_addr), 32'h000002);

        // Reset during WR_PULSE aborts the write; oe held low across release.
        bus.avr_data_in = 8'h55;
        bus.avr_we      = 1'b0;
        tick(); tick(); tick();
        checkOutput("pre-reset we_n", 32'(bus.sram_we_n), 32'd0);
        rst        = 1'b1;
        bus.avr_oe = 1'b0;
        tick();
        checkOutput("abort strobes", {bus.sram_ce_n, bus.sram_we_n}, 32'h3);
        checkOutput("abort data_oe", 32'(bus.sram_data_oe), 32'd0);
        checkOutput("abort addr", 32'(bus.sram_addr), 32'h0);
        checkOutput("abort busy", 32'(bus.avr_busy), 32'd0);
        tick();
        rst = 1'b0;
        busy_cnt = 0; ce = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.avr_busy) busy_cnt++;
            if (!bus.sram_ce_n) ce++;
        end
        bus.avr_oe = 1'b1;
        bus.avr_we = 1'b1;
        tick();
        checkOutput("held-low release busy", 32'(busy_cnt), 32'd0);
        checkOutput("held-low release ce_n", 32'(ce), 32'd0);
        checkOutput("held-low release addr", 32'(bus.sram_addr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
